// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: redirect input, instruction-memory port and decode handshake.
// The master modport is the fetch sequencer's view; slave is the surrounding logic.
interface fetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_target, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_target, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem read at a time, buffers words toward
// decode through a slot plus one-entry hold buffer, and flushes on branch/jump redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic            r_slot_valid;
  fetch_word_t     r_slot;
  fetch_word_t     r_hold;

  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_kill_nxt;
  logic            w_slot_valid_nxt;
  fetch_word_t     w_slot_nxt;
  fetch_word_t     w_hold_nxt;

  logic            w_take;
  logic [XLEN-1:0] w_target;
  fetch_word_t     w_fetched;

  assign w_take    = r_slot_valid & bus.instr_ready;
  assign w_target  = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign w_fetched = {bus.imem_rdata, r_pc};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update; a redirect overrides every other event
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_kill_nxt       = r_kill;
    w_slot_valid_nxt = r_slot_valid & ~w_take;
    w_slot_nxt       = r_slot;
    w_hold_nxt       = r_hold;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (bus.redirect_valid) w_pc_nxt = w_target;
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
        if (bus.redirect_valid) begin
          w_kill_nxt = 1'b1;
          w_pc_nxt   = w_target;
        end
      end
      S_WAIT: begin
        if (!bus.imem_rvalid) begin
          if (bus.redirect_valid) begin
            w_kill_nxt = 1'b1;
            w_pc_nxt   = w_target;
          end
        end else if (r_kill || bus.redirect_valid) begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = S_REQ;
          if (bus.redirect_valid) w_pc_nxt = w_target;
        end else if (!r_slot_valid || w_take) begin
          w_slot_nxt       = w_fetched;
          w_slot_valid_nxt = 1'b1;
          w_pc_nxt         = r_pc + XLEN'(4);
          w_state_nxt      = S_REQ;
        end else begin
          w_hold_nxt  = w_fetched;
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (bus.instr_ready) begin
          w_slot_nxt       = r_hold;
          w_slot_valid_nxt = 1'b1;
          w_state_nxt      = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (bus.redirect_valid) w_slot_valid_nxt = 1'b0;
  end

  // PC, kill flag, output slot and hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC_ALIGNED;
      r_kill       <= 1'b0;
      r_slot_valid <= 1'b0;
      r_slot       <= '0;
      r_hold       <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_slot_valid <= w_slot_valid_nxt;
      r_slot       <= w_slot_nxt;
      r_hold       <= w_hold_nxt;
    end
  end

  // The memory accepts in the same cycle, so the request is decoded straight from state
  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_slot_valid;
  assign bus.instr       = r_slot.instr;
  assign bus.instr_pc    = r_slot.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a variable-latency memory model driven on the falling
// edge, with hand-computed expectations for fetch order, backpressure, redirects and reset.
module tb_fetch_ctrl;

  logic clk;
  logic rst;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk;
  int n_fail;

  // memory model state: one outstanding read, response after lat cycles
  int          lat;
  int          cnt;
  logic        pend;
  logic [31:0] paddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance to the next falling edge and update the memory model for this cycle
  task automatic cyc();
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 1) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = paddr ^ 32'hDEAD_0000;
          pend            = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (bus.imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = bus.imem_addr;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    lat    = 1;
    cnt    = 0;
    pend   = 1'b0;
    paddr  = '0;
    rst                 = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = '0;
    bus.instr_ready     = 1'b1;

    cyc();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0100);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_ipc", bus.instr_pc, 32'd0);
    rst = 1'b0;

    // sequential fetch, 1-cycle memory
    cyc();
    chk("req0", 32'(bus.imem_req), 32'd1);
    chk("addr0", bus.imem_addr, 32'h0000_0100);
    cyc();
    chk("wait0_req", 32'(bus.imem_req), 32'd0);
    chk("wait0_valid", 32'(bus.instr_valid), 32'd0);
    cyc();
    chk("seq_valid0", 32'(bus.instr_valid), 32'd1);
    chk("seq_instr0", bus.instr, 32'hDEAD_0100);
    chk("seq_ipc0", bus.instr_pc, 32'h0000_0100);
    chk("seq_req1", 32'(bus.imem_req), 32'd1);
    chk("seq_addr1", bus.imem_addr, 32'h0000_0104);
    cyc();
    chk("seq_drain", 32'(bus.instr_valid), 32'd0);
    lat = 2;
    cyc();
    chk("seq_instr1", bus.instr, 32'hDEAD_0104);
    chk("seq_ipc1", bus.instr_pc, 32'h0000_0104);
    chk("seq_addr2", bus.imem_addr, 32'h0000_0108);

    // redirect while the 0x108 read is outstanding
    cyc();
    chk("rw_valid_pre", 32'(bus.instr_valid), 32'd0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    cyc();
    bus.redirect_valid = 1'b0;
    lat = 1;
    chk("rw_valid", 32'(bus.instr_valid), 32'd0);
    chk("rw_req", 32'(bus.imem_req), 32'd0);
    cyc();
    chk("rw_drop_valid", 32'(bus.instr_valid), 32'd0);
    chk("rw_req_t", 32'(bus.imem_req), 32'd1);
    chk("rw_addr_t", bus.imem_addr, 32'h0000_0200);
    cyc();
    cyc();
    chk("t_valid", 32'(bus.instr_valid), 32'd1);
    chk("t_instr", bus.instr, 32'hDEAD_0200);
    chk("t_ipc", bus.instr_pc, 32'h0000_0200);
    chk("t_addr", bus.imem_addr, 32'h0000_0204);
    bus.instr_ready = 1'b0;

    // redirect coincident with rvalid and a decode handshake
    cyc();
    chk("co_valid_pre", 32'(bus.instr_valid), 32'd1);
    chk("co_instr_pre", bus.instr, 32'hDEAD_0200);
    bus.instr_ready     = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0203;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("co_flush", 32'(bus.instr_valid), 32'd0);
    chk("co_req", 32'(bus.imem_req), 32'd1);
    chk("co_addr", bus.imem_addr, 32'h0000_0200);
    cyc();
    cyc();
    chk("co_instr", bus.instr, 32'hDEAD_0200);
    chk("co_ipc", bus.instr_pc, 32'h0000_0200);
    chk("co_addr2", bus.imem_addr, 32'h0000_0204);

    // redirect in REQ to the top word, then wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("rq_flush", 32'(bus.instr_valid), 32'd0);
    chk("rq_req", 32'(bus.imem_req), 32'd0);
    cyc();
    chk("rq_drop_valid", 32'(bus.instr_valid), 32'd0);
    chk("rq_addr", bus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    cyc();
    chk("wrap_instr", bus.instr, 32'h2152_FFFC);
    chk("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // reset during WAIT
    cyc();
    chk("mr_wait_req", 32'(bus.imem_req), 32'd0);
    rst = 1'b1;
    cyc();
    chk("mr_req", 32'(bus.imem_req), 32'd0);
    chk("mr_addr", bus.imem_addr, 32'h0000_0100);
    chk("mr_valid", 32'(bus.instr_valid), 32'd0);
    chk("mr_instr", bus.instr, 32'd0);
    chk("mr_ipc", bus.instr_pc, 32'd0);
    rst = 1'b0;
    cyc();
    chk("mr_restart", bus.imem_addr, 32'h0000_0100);
    chk("mr_restart_req", 32'(bus.imem_req), 32'd1);

    // backpressure: first word parks in the slot, second goes to the hold buffer
    bus.instr_ready = 1'b0;
    cyc();
    cyc();
    chk("bp_valid", 32'(bus.instr_valid), 32'd1);
    chk("bp_instr", bus.instr, 32'hDEAD_0100);
    chk("bp_addr", bus.imem_addr, 32'h0000_0104);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold_instr", bus.instr, 32'hDEAD_0100);
      chk("bp_hold_ipc", bus.instr_pc, 32'h0000_0100);
      chk("bp_hold_req", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready = 1'b1;
    cyc();
    chk("bp_out1_valid", 32'(bus.instr_valid), 32'd1);
    chk("bp_out1_instr", bus.instr, 32'hDEAD_0104);
    chk("bp_out1_ipc", bus.instr_pc, 32'h0000_0104);
    chk("bp_next_req", 32'(bus.imem_req), 32'd1);
    chk("bp_next_addr", bus.imem_addr, 32'h0000_0108);
    cyc();
    chk("bp_nodup", 32'(bus.instr_valid), 32'd0);
    cyc();
    chk("bp_out2_instr", bus.instr, 32'hDEAD_0108);
    chk("bp_out2_ipc", bus.instr_pc, 32'h0000_0108);
    chk("bp_out2_addr", bus.imem_addr, 32'h0000_010C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
